// File: rtl/trail_engine.sv
// Two-player light-cycle game engine: clears the board, moves both heads one tile per
// step, leaves permanent trails and decides the winner on frame, trail or head-on crashes.
package game_pkg;
    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PLAYER1 = 2'd1,
        PLAYER2 = 2'd2
    } tile;
endpackage

module trail_engine
    import game_pkg::*;
#(
    parameter int MAP_WIDTH  = 32,
    parameter int MAP_HEIGHT = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       step,
    input  logic [1:0] dir1,
    input  logic [1:0] dir2,
    output tile        map [MAP_WIDTH][MAP_HEIGHT],
    output logic       running,
    output logic       game_over,
    output logic [1:0] winner
);
    localparam int XW  = $clog2(MAP_WIDTH);
    localparam int YW  = $clog2(MAP_HEIGHT);
    localparam int P1X = 4;
    localparam int P2X = MAP_WIDTH - 5;
    localparam int PY  = MAP_HEIGHT / 2;

    typedef enum logic [2:0] {IDLE, CLEAR, RUN, EVAL, OVER} state_t;

    state_t          state, state_next;
    logic [XW-1:0]   cx, h1x, h2x, n1x, n2x, s1x, s2x;
    logic [YW-1:0]   cy, h1y, h2y, n1y, n2y, s1y, s2y;
    logic [1:0]      d1, d2;
    logic            clear_done;
    logic            frame1, frame2, same, crash1, crash2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Candidate heads from the currently latched directions.
    always_comb begin
        s1x = h1x;
        s1y = h1y;
        s2x = h2x;
        s2y = h2y;
        case (d1)
            2'b00:   s1y = h1y - YW'(1);
            2'b01:   s1x = h1x + XW'(1);
            2'b10:   s1y = h1y + YW'(1);
            default: s1x = h1x - XW'(1);
        endcase
        case (d2)
            2'b00:   s2y = h2y - YW'(1);
            2'b01:   s2x = h2x + XW'(1);
            2'b10:   s2y = h2y + YW'(1);
            default: s2x = h2x - XW'(1);
        endcase
    end

    always_comb begin
        frame1 = (n1x == '0) || (n1x == XW'(MAP_WIDTH - 1)) ||
                 (n1y == '0) || (n1y == YW'(MAP_HEIGHT - 1));
        frame2 = (n2x == '0) || (n2x == XW'(MAP_WIDTH - 1)) ||
                 (n2y == '0) || (n2y == YW'(MAP_HEIGHT - 1));
        same   = (n1x == n2x) && (n1y == n2y);
        crash1 = frame1 || same || (map[n1x][n1y] != EMPTY);
        crash2 = frame2 || same || (map[n2x][n2y] != EMPTY);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, OVER: if (start) state_next = CLEAR;
            CLEAR:      if (clear_done) state_next = RUN;
            RUN:        if (step) state_next = EVAL;
            EVAL:       state_next = (crash1 || crash2) ? OVER : RUN;
            default:    state_next = IDLE;
        endcase
    end

    assign running   = (state == RUN) || (state == EVAL);
    assign game_over = (state == OVER);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int x = 0; x < MAP_WIDTH; x++)
                for (int y = 0; y < MAP_HEIGHT; y++)
                    map[x][y] <= EMPTY;
            cx         <= '0;
            cy         <= '0;
            clear_done <= 1'b0;
            h1x        <= XW'(P1X);
            h1y        <= YW'(PY);
            h2x        <= XW'(P2X);
            h2y        <= YW'(PY);
            n1x        <= XW'(P1X);
            n1y        <= YW'(PY);
            n2x        <= XW'(P2X);
            n2y        <= YW'(PY);
            d1         <= 2'b01;
            d2         <= 2'b11;
            winner     <= 2'b00;
        end else begin
            case (state)
                IDLE, OVER: begin
                    if (start) begin
                        winner     <= 2'b00;
                        cx         <= '0;
                        cy         <= '0;
                        clear_done <= 1'b0;
                    end
                end
                CLEAR: begin
                    if (!clear_done) begin
                        map[cx][cy] <= EMPTY;
                        if (cy == YW'(MAP_HEIGHT - 1)) begin
                            cy <= '0;
                            if (cx == XW'(MAP_WIDTH - 1)) begin
                                cx         <= '0;
                                clear_done <= 1'b1;
                            end else begin
                                cx <= cx + XW'(1);
                            end
                        end else begin
                            cy <= cy + YW'(1);
                        end
                    end else begin
                        map[P1X][PY] <= PLAYER1;
                        map[P2X][PY] <= PLAYER2;
                        h1x <= XW'(P1X);
                        h1y <= YW'(PY);
                        h2x <= XW'(P2X);
                        h2y <= YW'(PY);
                        d1  <= 2'b01;
                        d2  <= 2'b11;
                    end
                end
                RUN: begin
                    // A request that exactly reverses the current heading is dropped.
                    if (dir1 != (d1 ^ 2'b10)) d1 <= dir1;
                    if (dir2 != (d2 ^ 2'b10)) d2 <= dir2;
                    if (step) begin
                        n1x <= s1x;
                        n1y <= s1y;
                        n2x <= s2x;
                        n2y <= s2y;
                    end
                end
                EVAL: begin
                    if (crash1 || crash2) begin
                        winner <= {crash1, crash2};
                    end else begin
                        map[n1x][n1y] <= PLAYER1;
                        map[n2x][n2y] <= PLAYER2;
                        h1x <= n1x;
                        h1y <= n1y;
                        h2x <= n2x;
                        h2y <= n2y;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
